sobel_window_sequencer: RTL
===========================

# sobel_window_sequencer

- Initiator side of the two-phase edge-detection custom-instruction protocol.
- Accepts a raster-order 8-bit grayscale pixel stream and buffers two previous lines.
- For every valid 3×3 window, issues the two custom-instruction phases to the edge-detection responder, then returns each 8-bit result on an output stream.
- Sits between the camera/DMA pixel path and the responder, replacing CPU-issued instructions.

## Interface
Parameters:
- customInstructionId, 8'd0, value driven on ciN during transactions
- imageWidth, 640, pixels per line (≥3)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- frameStart  input  1  pulse; clears row/column counters, latches threshold
- threshold  input  8  edge threshold, sampled when frameStart is applied
- pixelValid  input  1  pixel offered
- pixelReady  output  1  pixel accepted when pixelValid && pixelReady
- pixelData  input  8  grayscale pixel
- ciStart  output  1  one-cycle start pulse per phase
- ciN  output  8  instruction id
- ciValueA  output  32  operand A
- ciValueB  output  32  operand B
- ciDone  input  1  responder done; may arrive in the start cycle or later
- ciResult  input  32  responder result; bits [7:0] used
- edgeValid  output  1  result available
- edgeReady  input  1  result consumed when edgeValid && edgeReady
- edgeData  output  8  edge result
- busy  output  1  FSM not in IDLE

## Operation
- Counters:
  - col wraps imageWidth-1→0 and then increments row.
  - row saturates at 2.
- Window rows:
  - r0 is the oldest line, r2 is the current line.
  - p0..p2 = r0 cols c-2..c; p3..p5 = r1; p6..p8 = r2.
- A window is valid on pixel acceptance when row==2 && col≥2. Pixels that do not complete a window are accepted in IDLE with no transaction.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, OUT.
  - IDLE: pixelReady=1 (0 while a frameStart is pending). Valid-window accept → ISSUE1.
  - ISSUE1: ciStart=1, ciValueB=32'h1, ciValueA={p3,p2,p1,p0}. ciDone → ISSUE2, else → WAIT1.
  - WAIT1: ciStart=0, operands held. ciDone → ISSUE2.
  - ISSUE2: ciStart=1, ciValueA={p7,p6,p5,p4}, ciValueB={8'h00,thr,p8,8'h02}. ciDone → capture, OUT; else → WAIT2.
  - WAIT2: operands held. ciDone → capture ciResult[7:0], OUT.
  - OUT: edgeValid=1, edgeData held. edgeReady → IDLE.
- ciN=customInstructionId in ISSUE*/WAIT*. ciN, ciValueA and ciValueB are 0 in all other states.
- frameStart: registered as pending. It is applied on the first cycle the FSM is in IDLE (clears col, row, latches threshold), so a transaction in flight always completes. frameStart coinciding with a pixel in IDLE applies first; that pixel is not accepted that cycle.
- Line buffer write/read happens on pixel acceptance only.

## Timing
- Async reset clears all state. All outputs are 0 except pixelReady, which becomes 1 on the first cycle after release.
- Zero-latency responder:
  - pixel accepted at t → ISSUE1 at t+1 → ISSUE2 at t+2.
  - A responder with registered phase-2 done → WAIT2 at t+3 with done, edgeValid at t+4.
- Peak throughput: one window per 4 cycles plus OUT stall.
- No ciStart is issued while in OUT; backpressure on edgeReady stalls pixelReady.
- Operands are stable from ISSUE until the ciDone cycle inclusive.

## Structure
- Shared package holds:
  - the FSM state enum
  - phase opcodes (PHASE_LOAD=8'd1, PHASE_COMPUTE=8'd2)
  - the window-valid row index constant (2)
- One sub-module, sobel_line_buffer: two imageWidth×8 lines indexed by col, returning r0[col] and r1[col]. The 3×3 shift-register window lives in the sequencer.

## Test plan
- Reset: hold reset low → all outputs 0. Release → pixelReady=1, busy=0.
- imageWidth=4, threshold=0x20, pixels 0..11:
  - First transaction on pixel 10.
  - Phase 1: ciValueA=0x04020100, ciValueB=0x1.
  - Phase 2: ciValueA=0x09080605, ciValueB=0x00200A02.
  - Exactly 2 windows for the frame.
- Responder with 3-cycle done delay returning 0xAB → exactly one ciStart pulse per phase, operands stable throughout, edgeData=0xAB.
- edgeReady low for 10 cycles in OUT → edgeValid stays 1, pixelReady=0, no ciStart.
- frameStart during WAIT2 → result delivered, counters clear. The next 8 pixels (width 4) produce no transaction.
- Reset asserted during WAIT1 without a clock edge → ciStart, ciValueA, ciValueB, busy and edgeValid become 0 immediately.

Source files
------------

// File: rtl/sobel_window_sequencer_pkg.sv
// Shared types and constants for the Sobel window sequencer and its line buffer.
package sobel_window_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        ISSUE2,
        WAIT2,
        OUT
    } seq_state_e;

    localparam logic [7:0] PHASE_LOAD    = 8'd1;
    localparam logic [7:0] PHASE_COMPUTE = 8'd2;

    // Row counter value at which a full 3x3 window is available.
    localparam int WINDOW_ROW = 2;

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// Pixel stream, custom-instruction bus and edge stream seen by the sequencer.
interface sobel_window_sequencer_if;

    logic        pixelValid;
    logic        pixelReady;
    logic [7:0]  pixelData;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        edgeValid;
    logic        edgeReady;
    logic [7:0]  edgeData;

    modport master (
        input  pixelValid, pixelData, ciDone, ciResult, edgeReady,
        output pixelReady, ciStart, ciN, ciValueA, ciValueB, edgeValid, edgeData
    );

    modport slave (
        output pixelValid, pixelData, ciDone, ciResult, edgeReady,
        input  pixelReady, ciStart, ciN, ciValueA, ciValueB, edgeValid, edgeData
    );

endinterface

// File: rtl/sobel_window_sequencer_line_buffer.sv
// Two line memories indexed by column; each accepted pixel rotates r1 into r0.
module sobel_line_buffer #(
    parameter int imageWidth = 640
) (
    input  logic                          clock,
    input  logic                          wrEn,
    input  logic [$clog2(imageWidth)-1:0] col,
    input  logic [7:0]                    pixel,
    output logic [7:0]                    r0,
    output logic [7:0]                    r1
);
    import sobel_window_sequencer_pkg::*;

    logic [7:0] line0_mem [imageWidth];
    logic [7:0] line1_mem [imageWidth];

    // Read is combinational so the column above the incoming pixel joins the
    // window in the same cycle the pixel is accepted.
    assign r0 = line0_mem[col];
    assign r1 = line1_mem[col];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            line0_mem[col] <= line1_mem[col];
            line1_mem[col] <= pixel;
        end
    end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Builds 3x3 windows from a raster pixel stream and drives the two-phase edge
// custom instruction for each full window, returning the 8-bit result.
module sobel_window_sequencer #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         imageWidth          = 640
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frameStart,
    input  logic [7:0]                      threshold,
    output logic                            busy,
    sobel_window_sequencer_if.master        bus
);
    import sobel_window_sequencer_pkg::*;

    localparam int CW = $clog2(imageWidth);

    seq_state_e  state_q, state_d;
    logic [CW-1:0] col_q;
    logic [1:0]  row_q;
    logic [7:0]  thr_q, thr_pend_q, result_q;
    logic        pend_q, alive_q;
    logic [7:0]  r0, r1;
    logic [7:0]  col_in [3];
    logic        apply_fs, accept, window_hit, capture;
    logic [31:0] ph1_a, ph1_b, ph2_a, ph2_b;
    logic        unused_result_bits;

    // A pending or coincident frameStart wins over a pixel offered in IDLE.
    assign apply_fs      = alive_q && (state_q == IDLE) && (pend_q || frameStart);
    assign bus.pixelReady = alive_q && (state_q == IDLE) && !pend_q && !frameStart;
    assign accept        = bus.pixelValid && bus.pixelReady;
    assign window_hit    = accept && (row_q == 2'(WINDOW_ROW)) && (col_q >= CW'(2));
    assign capture       = ((state_q == ISSUE2) || (state_q == WAIT2)) && bus.ciDone;
    assign unused_result_bits = ^bus.ciResult[31:8];

    sobel_line_buffer #(.imageWidth(imageWidth)) u_line_buffer (
        .clock (clock),
        .wrEn  (accept),
        .col   (col_q),
        .pixel (bus.pixelData),
        .r0    (r0),
        .r1    (r1)
    );

    assign col_in[0] = r0;
    assign col_in[1] = r1;
    assign col_in[2] = bus.pixelData;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : row_g
            logic [7:0] tap_q [3];
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    tap_q[0] <= 8'd0;
                    tap_q[1] <= 8'd0;
                    tap_q[2] <= 8'd0;
                end else if (accept) begin
                    tap_q[0] <= tap_q[1];
                    tap_q[1] <= tap_q[2];
                    tap_q[2] <= col_in[gi];
                end
            end
        end
    endgenerate

    assign ph1_a = {row_g[1].tap_q[0], row_g[0].tap_q[2], row_g[0].tap_q[1], row_g[0].tap_q[0]};
    assign ph1_b = {24'h0, PHASE_LOAD};
    assign ph2_a = {row_g[2].tap_q[1], row_g[2].tap_q[0], row_g[1].tap_q[2], row_g[1].tap_q[1]};
    assign ph2_b = {8'h00, thr_q, row_g[2].tap_q[2], PHASE_COMPUTE};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= 2'd0;
            thr_q      <= 8'd0;
            thr_pend_q <= 8'd0;
            result_q   <= 8'd0;
            pend_q     <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            state_q <= state_d;
            if (frameStart && !apply_fs) begin
                pend_q     <= 1'b1;
                thr_pend_q <= threshold;
            end
            if (apply_fs) begin
                pend_q <= 1'b0;
                col_q  <= '0;
                row_q  <= 2'd0;
                thr_q  <= frameStart ? threshold : thr_pend_q;
            end else if (accept) begin
                if (col_q == CW'(imageWidth - 1)) begin
                    col_q <= '0;
                    if (row_q != 2'(WINDOW_ROW)) row_q <= row_q + 2'd1;
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (capture) result_q <= bus.ciResult[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.ciStart  = 1'b0;
        bus.ciN      = 8'd0;
        bus.ciValueA = 32'd0;
        bus.ciValueB = 32'd0;
        bus.edgeValid = 1'b0;
        case (state_q)
            IDLE: if (window_hit) state_d = ISSUE1;
            ISSUE1, WAIT1: begin
                bus.ciStart  = (state_q == ISSUE1);
                bus.ciN      = customInstructionId;
                bus.ciValueA = ph1_a;
                bus.ciValueB = ph1_b;
                if (bus.ciDone) state_d = ISSUE2;
                else            state_d = WAIT1;
            end
            ISSUE2, WAIT2: begin
                bus.ciStart  = (state_q == ISSUE2);
                bus.ciN      = customInstructionId;
                bus.ciValueA = ph2_a;
                bus.ciValueB = ph2_b;
                if (bus.ciDone) state_d = OUT;
                else            state_d = WAIT2;
            end
            OUT: begin
                bus.edgeValid = 1'b1;
                if (bus.edgeReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.edgeData = result_q;
    assign busy         = (state_q != IDLE);

endmodule
